// File: rtl/uart_pkg.sv
// Shared UART constants and the frame decoder state type.
package uart_pkg;

  localparam int unsigned       UART_DATA_WIDTH = 8;
  localparam logic [7:0]        UART_SYNC_BYTE  = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    CHECK
  } frame_state_t;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / word-write-out bundle between the UART receiver side and the loader.
interface uart_frame_decoder_if #(
  parameter int unsigned DATA_WIDTH = uart_pkg::UART_DATA_WIDTH,
  parameter int unsigned WORD_BYTES = 4
) ();

  logic                             rx_done;
  logic [DATA_WIDTH-1:0]            rx_data;
  logic                             wr_en;
  logic [DATA_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH*WORD_BYTES-1:0] wr_data;
  logic                             frame_err;
  logic                             busy;

  modport master (
    output rx_done, rx_data,
    input  wr_en, wr_addr, wr_data, frame_err, busy
  );

  modport slave (
    input  rx_done, rx_data,
    output wr_en, wr_addr, wr_data, frame_err, busy
  );

endinterface

// File: rtl/uart_timeout_counter.sv
// Inter-byte idle timer: clears on clr, counts while en, flags when it hits TIMEOUT_CYCLES-1.
module uart_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/ADDR/data/CHK byte frames from the UART receiver into word writes.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int unsigned           WORD_BYTES     = 4,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DATA_WIDTH'(UART_SYNC_BYTE),
  parameter int unsigned           TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               arst_n,
  uart_frame_decoder_if.slave bus
);

  localparam int unsigned WORD_W = DATA_WIDTH * WORD_BYTES;
  localparam int unsigned CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

  frame_state_t          state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_WIDTH-1:0] chk, chk_n;
  logic [DATA_WIDTH-1:0] addr_reg, addr_n;
  logic [WORD_W-1:0]     data_reg, data_n;
  logic                  wr_en, wr_en_n;
  logic                  frame_err, frame_err_n;
  logic [DATA_WIDTH-1:0] wr_addr, wr_addr_n;
  logic [WORD_W-1:0]     wr_data, wr_data_n;

  logic timer_clr, timer_en, timer_expired, timeout;

  // Timer only runs inside a frame; IDLE holds it cleared so SYNC starts from zero.
  assign timer_clr = bus.rx_done || (state == IDLE);
  assign timer_en  = (state != IDLE);
  assign timeout   = (state != IDLE) && !bus.rx_done && timer_expired;

  uart_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    chk_n       = chk;
    addr_n      = addr_reg;
    data_n      = data_reg;
    wr_en_n     = 1'b0;
    frame_err_n = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;

    case (state)
      IDLE: begin
        if (bus.rx_done && (bus.rx_data == SYNC_BYTE)) begin
          state_n = ADDR;
          chk_n   = '0;
          cnt_n   = '0;
        end
      end
      ADDR: begin
        if (bus.rx_done) begin
          addr_n  = bus.rx_data;
          chk_n   = bus.rx_data;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bus.rx_done) begin
          for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (cnt == CNT_W'(i)) data_n[i*DATA_WIDTH +: DATA_WIDTH] = bus.rx_data;
          end
          chk_n = chk ^ bus.rx_data;
          if (cnt == LAST_IDX) state_n = CHECK;
          else                 cnt_n   = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (bus.rx_done) begin
          if (bus.rx_data == chk) begin
            wr_en_n   = 1'b1;
            wr_addr_n = addr_reg;
            wr_data_n = data_reg;
          end else begin
            frame_err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout) begin
      frame_err_n = 1'b1;
      state_n     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      chk       <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      chk       <= chk_n;
      addr_reg  <= addr_n;
      data_reg  <= data_n;
      wr_en     <= wr_en_n;
      frame_err <= frame_err_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
    end
  end

  assign bus.wr_en     = wr_en;
  assign bus.frame_err = frame_err;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench: byte-queue frame model compared every cycle, plus directed literal checks.
module tb_uart_frame_decoder;

  localparam int unsigned T  = 100;
  localparam int unsigned WB = 4;

  logic clk;
  logic arst_n;

  uart_frame_decoder_if #(.DATA_WIDTH(8), .WORD_BYTES(WB)) bus ();

  uart_frame_decoder #(
    .DATA_WIDTH    (8),
    .WORD_BYTES    (WB),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned wr_cnt = 0;
  int unsigned err_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame = queue of bytes after SYNC; decided when full or idle too long.
  logic        in_frame;
  logic [7:0]  q[$];
  int unsigned idle;
  logic        exp_wr_en, exp_err;
  logic [7:0]  exp_addr;
  logic [31:0] exp_data;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      in_frame  = 1'b0;
      q.delete();
      idle      = 0;
      exp_wr_en = 1'b0;
      exp_err   = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
    end else begin
      exp_wr_en = 1'b0;
      exp_err   = 1'b0;
      if (!in_frame) begin
        if (bus.rx_done && bus.rx_data == 8'hA5) begin
          in_frame = 1'b1;
          q.delete();
          idle = 0;
        end
      end else if (bus.rx_done) begin
        idle = 0;
        q.push_back(bus.rx_data);
        if (q.size() == WB + 2) begin
          logic [7:0] x;
          x = '0;
          for (int i = 0; i < WB + 1; i++) x ^= q[i];
          if (x == q[WB+1]) begin
            exp_wr_en = 1'b1;
            exp_addr  = q[0];
            for (int i = 0; i < WB; i++) exp_data[8*i +: 8] = q[1+i];
          end else begin
            exp_err = 1'b1;
          end
          in_frame = 1'b0;
        end
      end else begin
        idle++;
        if (idle == T) begin
          exp_err  = 1'b1;
          in_frame = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("wr_en",     {63'd0, bus.wr_en},     {63'd0, exp_wr_en});
    check("frame_err", {63'd0, bus.frame_err}, {63'd0, exp_err});
    check("busy",      {63'd0, bus.busy},      {63'd0, in_frame});
    check("wr_addr",   {56'd0, bus.wr_addr},   {56'd0, exp_addr});
    check("wr_data",   {32'd0, bus.wr_data},   {32'd0, exp_data});
    if (bus.wr_en)     wr_cnt++;
    if (bus.frame_err) err_cnt++;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick(1);
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
    tick(gap);
  endtask

  // long_idx selects which byte is followed by a gap of long_len cycles (-1 for none).
  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input logic [7:0] flip,
                            input int long_idx, input int unsigned long_len);
    logic [7:0] fb[WB+3];
    logic [7:0] c;
    fb[0] = 8'hA5;
    fb[1] = addr;
    c = addr;
    for (int i = 0; i < WB; i++) begin
      fb[2+i] = data[8*i +: 8];
      c ^= data[8*i +: 8];
    end
    fb[WB+2] = c ^ flip;
    for (int i = 0; i < WB + 3; i++)
      send_byte(fb[i], (i == long_idx) ? long_len : $urandom_range(0, 2));
  endtask

  task automatic send_list(input logic [7:0] b[], input int unsigned gap);
    foreach (b[i]) send_byte(b[i], gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    arst_n      = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    tick(3);
    arst_n = 1'b1;
    tick(1);

    check("rst_wr_addr", {56'd0, bus.wr_addr}, 64'h0);
    check("rst_wr_data", {32'd0, bus.wr_data}, 64'h0);
    check("rst_busy",    {63'd0, bus.busy},    64'h0);

    send_list('{8'hA5, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 8'h18}, 1);
    tick(2);
    check("valid_wr_cnt",  64'(wr_cnt),  64'd1);
    check("valid_err_cnt", 64'(err_cnt), 64'd0);
    check("valid_addr",    {56'd0, bus.wr_addr}, 64'h10);
    check("valid_data",    {32'd0, bus.wr_data}, 64'h12345678);

    send_list('{8'hA5, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 8'h19}, 0);
    tick(2);
    check("badchk_err_cnt", 64'(err_cnt), 64'd1);
    check("badchk_wr_cnt",  64'(wr_cnt),  64'd1);
    check("badchk_data",    {32'd0, bus.wr_data}, 64'h12345678);

    send_list('{8'h00, 8'hFF, 8'h5A}, 1);
    check("garbage_busy", {63'd0, bus.busy}, 64'h0);
    send_list('{8'hA5, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 8'h18}, 0);
    tick(2);
    check("garbage_wr_cnt",  64'(wr_cnt),  64'd2);
    check("garbage_err_cnt", 64'(err_cnt), 64'd1);

    send_list('{8'hA5, 8'h20, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h20}, 0);
    tick(2);
    check("syncpay_addr", {56'd0, bus.wr_addr}, 64'h20);
    check("syncpay_data", {32'd0, bus.wr_data}, 64'hA5A5A5A5);
    check("syncpay_wr_cnt", 64'(wr_cnt), 64'd3);

    send_list('{8'hA5, 8'h10}, 0);
    tick(T + 20);
    check("timeout_err_cnt", 64'(err_cnt), 64'd2);
    check("timeout_busy",    {63'd0, bus.busy}, 64'h0);
    send_list('{8'hA5, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 8'h18}, 0);
    tick(2);
    check("post_timeout_wr_cnt", 64'(wr_cnt), 64'd4);

    send_list('{8'hA5, 8'h10, 8'h78}, 0);
    arst_n = 1'b0;
    tick(2);
    arst_n = 1'b1;
    send_list('{8'h56, 8'h34, 8'h12, 8'h18}, 0);
    tick(2);
    check("rstmid_wr_cnt",  64'(wr_cnt),  64'd4);
    check("rstmid_err_cnt", 64'(err_cnt), 64'd2);
    check("rstmid_addr",    {56'd0, bus.wr_addr}, 64'h0);
    check("rstmid_data",    {32'd0, bus.wr_data}, 64'h0);

    for (int n = 0; n < 200; n++) begin
      int unsigned kind;
      logic [7:0]  a;
      logic [31:0] d;
      kind = $urandom_range(0, 9);
      a    = 8'($urandom);
      d    = $urandom;
      if ($urandom_range(0, 3) == 0) d[15:8] = 8'hA5;
      case (kind)
        6: send_frame(a, d, 8'($urandom_range(1, 255)), -1, 0);
        7: repeat ($urandom_range(1, 4)) send_byte(8'($urandom_range(0, 8'hA4)), $urandom_range(0, 2));
        8: begin
          send_byte(8'hA5, 0);
          repeat ($urandom_range(0, 4)) send_byte(8'($urandom), $urandom_range(0, 2));
          send_byte(8'($urandom), T + $urandom_range(0, 2) - 1);
        end
        9: send_frame(a, d, 8'h00, int'($urandom_range(0, WB + 1)), T - 1 + $urandom_range(0, 1));
        default: send_frame(a, d, 8'h00, -1, 0);
      endcase
    end
    tick(T + 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
